// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the core's data-memory request interface. Services one
//   RV32I load/store at a time (LB/LH/LW/LBU/LHU, SB/SH/SW) against an
//   internal word-wide RAM. Sub-word stores use read-modify-write. Misaligned,
//   out-of-range and illegal-funct3 requests are answered with a fault and do
//   not touch the RAM.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  block can accept a request this cycle (IDLE only)
//   req_rw     0 = load, 1 = store
//   req_func   RV32I funct3 of the load or store
//   req_addr   byte address
//   req_wdata  store data, right-aligned
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load result, extended; 0 for stores and faults
//   rsp_fault  access faulted, qualified by rsp_valid
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [2:0]  req_func,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, RESP} state_t;

  state_t        state_reg;
  logic          ready_reg;
  logic          rsp_valid_reg;
  logic          rsp_fault_reg;
  logic [31:0]   rsp_rdata_reg;

  // Request fields captured at acceptance
  logic          rw_reg;
  logic [2:0]    func_reg;
  logic [1:0]    lane_reg;
  logic [AW-1:0] idx_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   merge_reg;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;

  logic          accept;
  logic          func_legal;
  logic          misaligned;
  logic          out_of_range;
  logic          req_fault;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [31:0]   store_rep;
  logic [31:0]   merge_data;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_fault = rsp_fault_reg;

  assign accept = req_valid & ready_reg;

  // Fault classification of the live request (only consumed at acceptance)
  always_comb begin
    func_legal = 1'b0;
    misaligned = 1'b0;
    case (req_func)
      3'b000: func_legal = 1'b1;
      3'b001: begin
        func_legal = 1'b1;
        misaligned = req_addr[0];
      end
      3'b010: begin
        func_legal = 1'b1;
        misaligned = |req_addr[1:0];
      end
      // LBU/LHU exist only as loads
      3'b100: func_legal = ~req_rw;
      3'b101: begin
        func_legal = ~req_rw;
        misaligned = req_addr[0];
      end
      default: func_legal = 1'b0;
    endcase
  end

  // DEPTH_WORDS is a power of two, so any set bit above the byte range is out of range
  assign out_of_range = |req_addr[31:AW+2];
  assign req_fault    = ~func_legal | misaligned | out_of_range;

  // Load extraction from the word read at acceptance
  assign sel_byte = ram_q[8*lane_reg +: 8];
  assign sel_half = lane_reg[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    load_data = ram_q;
    case (func_reg)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = ram_q;
    endcase
  end

  // Store lanes: replicate the right-aligned data to every lane, then let the
  // byte enables pick which lanes replace the read value.
  always_comb begin
    byte_en   = 4'b1111;
    store_rep = wdata_reg;
    case (func_reg[1:0])
      2'b00: begin
        byte_en   = 4'(4'b0001 << lane_reg);
        store_rep = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        byte_en   = lane_reg[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{wdata_reg[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        store_rep = wdata_reg;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge_lane
      assign merge_data[8*gi +: 8] = byte_en[gi] ? store_rep[8*gi +: 8] : ram_q[8*gi +: 8];
    end
  endgenerate

  // A reset drops the FSM to IDLE immediately, so a pending WR/MERGE write
  // never reaches its committing edge.
  assign ram_we    = (state_reg == WR) || (state_reg == MERGE);
  assign ram_wdata = (state_reg == WR) ? wdata_reg : merge_reg;

  // RAM: synchronous write, registered read issued on the acceptance edge
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[idx_reg] <= ram_wdata;
    end
    if (accept) begin
      ram_q <= mem[req_addr[AW+1:2]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_fault_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      rw_reg        <= 1'b0;
      func_reg      <= 3'd0;
      lane_reg      <= 2'd0;
      idx_reg       <= '0;
      wdata_reg     <= 32'd0;
      merge_reg     <= 32'd0;
    end else begin
      // Response outputs are single-cycle pulses unless set below
      rsp_valid_reg <= 1'b0;
      rsp_fault_reg <= 1'b0;
      rsp_rdata_reg <= 32'd0;
      ready_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (accept) begin
            ready_reg <= 1'b0;
            rw_reg    <= req_rw;
            func_reg  <= req_func;
            lane_reg  <= req_addr[1:0];
            idx_reg   <= req_addr[AW+1:2];
            wdata_reg <= req_wdata;
            if (req_fault) begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_fault_reg <= 1'b1;
            end else if (req_rw && (req_func[1:0] == 2'b10)) begin
              state_reg <= WR;
            end else begin
              state_reg <= RD;
            end
          end
        end
        RD: begin
          if (rw_reg) begin
            state_reg <= MERGE;
            merge_reg <= merge_data;
          end else begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= load_data;
          end
        end
        MERGE: begin
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
        end
        WR: begin
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
        end
        RESP: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int checks;
  int errors;

  data_mem_responder #(.DEPTH_WORDS(1024), .AW(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_func  (req_func),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rw;
    logic [2:0]  func;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        fault;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rw, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int lat, input logic [31:0] rd, input logic flt);
    vec_t v;
    v.name = nm; v.rw = rw; v.func = f; v.addr = a; v.wdata = wd;
    v.lat = lat; v.rdata = rd; v.fault = flt;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called #1 after a rising edge. Waits (bounded) for req_ready, issues the
  // request for one edge, scrambles the inputs afterwards and measures the
  // response latency in cycles after the acceptance edge. Returns in the
  // response cycle (or lat=-1 on timeout).
  task automatic do_req(input logic rw, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic flt);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b1; req_rw = rw; req_func = f; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_rw = ~rw; req_func = 3'b111; req_addr = ~a; req_wdata = ~wd;
    lat = -1; rd = 32'd0; flt = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (rsp_valid) begin
        lat = c; rd = rsp_rdata; flt = rsp_fault;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        flt;
    bit          seen;
    int          accepts;
    int          rsps;
    int          overlap;

    checks = 0; errors = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_func = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;

    add("sw_10",      1, 3'b010, 32'h10,   32'hDEADBEEF, 2, 32'h0,        0);
    add("lw_10",      0, 3'b010, 32'h10,   32'h0,        2, 32'hDEADBEEF, 0);
    add("lb_13",      0, 3'b000, 32'h13,   32'h0,        2, 32'hFFFFFFDE, 0);
    add("lbu_13",     0, 3'b100, 32'h13,   32'h0,        2, 32'h000000DE, 0);
    add("lh_12",      0, 3'b001, 32'h12,   32'h0,        2, 32'hFFFFDEAD, 0);
    add("lhu_10",     0, 3'b101, 32'h10,   32'h0,        2, 32'h0000BEEF, 0);
    add("sb_11",      1, 3'b000, 32'h11,   32'h12345677, 3, 32'h0,        0);
    add("lw_after_sb",0, 3'b010, 32'h10,   32'h0,        2, 32'hDEAD77EF, 0);
    add("sh_12",      1, 3'b001, 32'h12,   32'h0000CAFE, 3, 32'h0,        0);
    add("lw_after_sh",0, 3'b010, 32'h10,   32'h0,        2, 32'hCAFE77EF, 0);
    add("f_lw_12",    0, 3'b010, 32'h12,   32'h0,        1, 32'h0,        1);
    add("f_sh_11",    1, 3'b001, 32'h11,   32'hFFFFFFFF, 1, 32'h0,        1);
    add("f_ld_011",   0, 3'b011, 32'h10,   32'h0,        1, 32'h0,        1);
    add("f_sw_oor",   1, 3'b010, 32'h1000, 32'h0BADF00D, 1, 32'h0,        1);
    add("lw_chk",     0, 3'b010, 32'h10,   32'h0,        2, 32'hCAFE77EF, 0);
    add("lb_10",      0, 3'b000, 32'h10,   32'h0,        2, 32'hFFFFFFEF, 0);
    add("lh_10",      0, 3'b001, 32'h10,   32'h0,        2, 32'h000077EF, 0);
    add("lhu_12",     0, 3'b101, 32'h12,   32'h0,        2, 32'h0000CAFE, 0);
    add("lh_12b",     0, 3'b001, 32'h12,   32'h0,        2, 32'hFFFFCAFE, 0);
    add("sb_13",      1, 3'b000, 32'h13,   32'h000000AB, 3, 32'h0,        0);
    add("lw_after_sb13",0,3'b010,32'h10,   32'h0,        2, 32'hABFE77EF, 0);
    add("sw_last",    1, 3'b010, 32'hFFC,  32'h80000001, 2, 32'h0,        0);
    add("lw_last",    0, 3'b010, 32'hFFC,  32'h0,        2, 32'h80000001, 0);
    add("lb_fff",     0, 3'b000, 32'hFFF,  32'h0,        2, 32'hFFFFFF80, 0);
    add("f_lw_oor",   0, 3'b010, 32'h1000, 32'h0,        1, 32'h0,        1);
    add("f_st_100",   1, 3'b100, 32'h10,   32'h000000FF, 1, 32'h0,        1);
    add("sw_20",      1, 3'b010, 32'h20,   32'h55AA33CC, 2, 32'h0,        0);
    add("f_lh_13",    0, 3'b001, 32'h13,   32'h0,        1, 32'h0,        1);
    add("lw_unchanged",0,3'b010, 32'h10,   32'h0,        2, 32'hABFE77EF, 0);

    // Reset state
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      do_req(vecs[i].rw, vecs[i].func, vecs[i].addr, vecs[i].wdata, lat, rd, flt);
      $display("txn %0d %s rw=%0b f=%0b addr=%h wdata=%h lat=%0d rdata=%h fault=%0b",
               i, vecs[i].name, vecs[i].rw, vecs[i].func, vecs[i].addr, vecs[i].wdata,
               lat, rd, flt);
      check({vecs[i].name, "_lat"},   32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_rdata"}, rd, vecs[i].rdata);
      check({vecs[i].name, "_fault"}, {31'd0, flt}, {31'd0, vecs[i].fault});
    end

    // Abort: reset pulse during WR of SW 0x20 must suppress write and response
    begin
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      req_valid = 1'b1; req_rw = 1'b1; req_func = 3'b010;
      req_addr = 32'h20; req_wdata = 32'h11111111;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("abort_ready_in_rst", {31'd0, req_ready}, 32'd0);
      check("abort_rsp_in_rst", {31'd0, rsp_valid}, 32'd0);
      #1 rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen = 1'b1;
      end
      $display("txn abort sw_20 wdata=11111111 rsp_seen=%0b", seen);
      check("abort_no_rsp", {31'd0, seen}, 32'd0);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, flt);
    $display("txn lw_20_after_abort lat=%0d rdata=%h fault=%0b", lat, rd, flt);
    check("abort_lw_lat", 32'(lat), 32'd2);
    check("abort_lw_rdata", rd, 32'h55AA33CC);

    // req_valid held high through back-to-back LW 0x10
    begin
      int n;
      n = 0;
      while (!req_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    accepts = 0; rsps = 0; overlap = 0;
    req_valid = 1'b1; req_rw = 1'b0; req_func = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) accepts++;
      if (rsp_valid) begin
        rsps++;
        check("hold_rdata", rsp_rdata, 32'hABFE77EF);
      end
      if (req_ready && rsp_valid) overlap++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) begin
        rsps++;
        check("hold_rdata", rsp_rdata, 32'hABFE77EF);
      end
      @(posedge clk); #1;
    end
    $display("txn hold accepts=%0d rsps=%0d overlap=%0d", accepts, rsps, overlap);
    check("hold_accepts", 32'(accepts), 32'd4);
    check("hold_rsps", 32'(rsps), 32'd4);
    check("hold_overlap", 32'(overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
